// File: rtl/fifo_arb_pkg.sv
// Package: fifo_arb_pkg
// Types and helpers that the read-side FIFO arbiter and its round-robin picker share.
//   arb_state_e : arbiter FSM state (IDLE = no grant, GRANT = one queue owns the stream)
//   qw()        : queue-id width, max(1, $clog2(nq))
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned qw(input int unsigned nq);
    return (nq > 2) ? $clog2(nq) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Module: rr_picker
// Combinational rotating-priority picker. The search starts at the entry after i_last,
// so the most recent owner has the lowest priority.
// Ports:
//   i_req  [NQ]  request vector (eligible queues)
//   i_last [QW]  index of the previous owner
//   o_any        at least one request is set
//   o_pick [QW]  first requester found at i_last+1, i_last+2, ... mod NQ
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NQ = 4,
  localparam int unsigned QW = qw(NQ)
) (
  input  logic [NQ-1:0] i_req,
  input  logic [QW-1:0] i_last,
  output logic          o_any,
  output logic [QW-1:0] o_pick
);

  logic [QW-1:0] w_idx;

  always_comb begin
    o_any  = 1'b0;
    o_pick = '0;
    w_idx  = '0;
    // k runs 1..NQ so that i_last itself is checked last.
    for (int unsigned k = 1; k <= NQ; k++) begin
      w_idx = QW'((32'(i_last) + k) % NQ);
      if (!o_any && i_req[w_idx]) begin
        o_any  = 1'b1;
        o_pick = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Module: fifo_rd_arbiter
// Read-side scheduler for NQ async-FIFO read ports in the read clock domain. Grants one
// non-empty, enabled queue at a time in round-robin order, keeps the grant for up to
// BURST words, pulses the owner's rinc and registers the word into a valid/ready stream
// tagged with the source queue id.
// Ports:
//   i_rclk      read-domain clock
//   i_rrst      synchronous active-high reset
//   i_q_en      per-queue enable mask
//   i_rempty    per-queue empty flags
//   i_rdata     per-queue read data, queue q at [q*DSIZE +: DSIZE]
//   o_rinc      per-queue read increment, one-hot or zero
//   o_m_valid   output word valid
//   i_m_ready   downstream accept
//   o_m_data    output word
//   o_m_qid     source queue of o_m_data
//   o_busy      a grant is active
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NQ    = 4,
  parameter  int unsigned DSIZE = 8,
  parameter  int unsigned BURST = 4,
  localparam int unsigned QW    = qw(NQ)
) (
  input  logic                i_rclk,
  input  logic                i_rrst,
  input  logic [NQ-1:0]       i_q_en,
  input  logic [NQ-1:0]       i_rempty,
  input  logic [NQ*DSIZE-1:0] i_rdata,
  output logic [NQ-1:0]       o_rinc,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [DSIZE-1:0]    o_m_data,
  output logic [QW-1:0]       o_m_qid,
  output logic                o_busy
);

  localparam int unsigned BW = $clog2(BURST) + 1;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [QW-1:0]    r_owner;
  logic [QW-1:0]    r_last;
  logic [BW-1:0]    r_burst_cnt;
  logic             r_m_valid;
  logic [DSIZE-1:0] r_m_data;
  logic [QW-1:0]    r_m_qid;

  logic [NQ-1:0]    w_eligible;
  logic             w_own_elig;
  logic             w_load;
  logic             w_last_beat;
  logic             w_release;
  logic             w_any;
  logic [QW-1:0]    w_pick;
  logic [DSIZE-1:0] w_rdata [NQ];

  for (genvar g = 0; g < NQ; g++) begin : g_rdata_split
    assign w_rdata[g] = i_rdata[g*DSIZE +: DSIZE];
  end

  assign w_eligible  = i_q_en & ~i_rempty;
  assign w_own_elig  = w_eligible[r_owner];
  // A word moves only when the output register is empty or being drained this cycle.
  assign w_load      = (r_state == GRANT) && w_own_elig && (!r_m_valid || i_m_ready);
  assign w_last_beat = (r_burst_cnt == BW'(BURST - 1));
  // A stall leaves w_load low and w_own_elig high, so it can never cause a release.
  assign w_release   = (r_state == GRANT) && ((w_load && w_last_beat) || !w_own_elig);

  rr_picker #(
    .NQ (NQ)
  ) u_rr_picker (
    .i_req  (w_eligible),
    .i_last (r_last),
    .o_any  (w_any),
    .o_pick (w_pick)
  );

  // FSM state register
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; rinc is gated by reset so no pop happens while the arbiter is cleared.
  always_comb begin
    o_rinc = '0;
    if (w_load && !i_rrst) begin
      o_rinc[r_owner] = 1'b1;
    end
    o_busy = (r_state != IDLE);
  end

  // Grant owner, round-robin history and burst counter
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_owner     <= '0;
      r_last      <= QW'(NQ - 1);
      r_burst_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_pick;
            r_burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_last      <= r_owner;
            r_burst_cnt <= '0;
          end else if (w_load) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: r_burst_cnt <= '0;
      endcase
    end
  end

  // Output stream register
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_qid   <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_rdata[r_owner];
      r_m_qid   <= r_owner;
    end else if (i_m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_m_qid   = r_m_qid;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter (NQ=4, DSIZE=8, BURST=4). Each FIFO is a pointer pair;
// the word at read pointer p of queue q is {q[1:0], p[5:0]}, so the stream order
// can be checked against hand-derived sequences.
module tb_fifo_rd_arbiter;

  logic        clk = 1'b0;
  logic        rrst;
  logic [3:0]  q_en;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  rinc;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_qid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int rd_ptr   [4] = '{default: 0};
  int wr_ptr   [4] = '{default: 0};
  int rinc_cnt [4] = '{default: 0};

  int acc_q [$];
  int acc_d [$];
  int acc_c [$];

  fifo_rd_arbiter #(
    .NQ    (4),
    .DSIZE (8),
    .BURST (4)
  ) dut (
    .i_rclk    (clk),
    .i_rrst    (rrst),
    .i_q_en    (q_en),
    .i_rempty  (rempty),
    .i_rdata   (rdata),
    .o_rinc    (rinc),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_m_data  (m_data),
    .o_m_qid   (m_qid),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(input int q, input int idx);
    return {q[1:0], idx[5:0]};
  endfunction

  // FIFO read side
  always_comb begin
    rempty = '0;
    rdata  = '0;
    for (int q = 0; q < 4; q++) begin
      rempty[q]        = (rd_ptr[q] == wr_ptr[q]);
      rdata[q*8 +: 8]  = {2'(q), 6'(rd_ptr[q])};
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rinc != 4'h0) begin
      chk("rinc_on_empty", {28'h0, rinc & rempty}, 32'h0);
      chk("rinc_onehot", {31'h0, $onehot0(rinc)}, 32'h1);
    end
    for (int q = 0; q < 4; q++) begin
      if (rinc[q]) begin
        rd_ptr[q]   <= rd_ptr[q] + 1;
        rinc_cnt[q] <= rinc_cnt[q] + 1;
      end
    end
    if (!rrst && m_valid && m_ready) begin
      acc_q.push_back(int'(m_qid));
      acc_d.push_back(int'(m_data));
      acc_c.push_back(cyc);
    end
  end

  task automatic clear_log();
    acc_q.delete();
    acc_d.delete();
    acc_c.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_count"}, acc_q.size(), n);
  endtask

  task automatic chk_entry(input string tag, input int i, input int q, input int idx);
    if (i < acc_q.size()) begin
      chk({tag, "_qid"}, acc_q[i], q);
      chk({tag, "_data"}, acc_d[i], {24'h0, exp_word(q, idx)});
    end
  endtask

  int b0, b1, b2, b3, rc;
  int bq [4];

  initial begin
    rrst    = 1'b1;
    q_en    = 4'hF;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rrst = 1'b0;

    // 1: idle with all queues empty
    chk("t1_data", {24'h0, m_data}, 32'h0);
    chk("t1_qid", {30'h0, m_qid}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_rinc", {28'h0, rinc}, 32'h0);
      chk("t1_valid", {31'h0, m_valid}, 32'h0);
      chk("t1_busy", {31'h0, busy}, 32'h0);
    end

    // 2: six words in Q2 -> burst of 4, one bubble, then 2
    clear_log();
    b2 = wr_ptr[2];
    rc = rinc_cnt[2];
    wr_ptr[2] += 6;
    wait_log(6, 40, "t2");
    repeat (3) @(negedge clk);
    chk("t2_rinc_pulses", rinc_cnt[2] - rc, 6);
    for (int i = 0; i < 6; i++) chk_entry("t2", i, 2, b2 + i);
    for (int i = 1; i < 6 && i < acc_c.size(); i++)
      chk("t2_gap", acc_c[i] - acc_c[i-1], (i == 4) ? 2 : 1);
    chk("t2_busy_end", {31'h0, busy}, 32'h0);

    // 3: all four queues hold 8 words -> 0x4,1x4,2x4,3x4 twice
    rrst = 1'b1;
    @(negedge clk);
    rrst = 1'b0;
    clear_log();
    for (int q = 0; q < 4; q++) begin
      bq[q] = wr_ptr[q];
      wr_ptr[q] += 8;
    end
    wait_log(32, 200, "t3");
    for (int i = 0; i < 32; i++)
      chk_entry("t3", i, (i / 4) % 4, bq[(i / 4) % 4] + (i / 16) * 4 + (i % 4));

    // 4: Q1 streaming, back-pressure for 5 cycles
    repeat (3) @(negedge clk);
    clear_log();
    b1 = wr_ptr[1];
    wr_ptr[1] += 8;
    @(negedge clk);
    @(negedge clk);
    chk("t4_first_valid", {31'h0, m_valid}, 32'h1);
    m_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t4_stall_rinc", {28'h0, rinc}, 32'h0);
      chk("t4_stall_valid", {31'h0, m_valid}, 32'h1);
      chk("t4_stall_data", {24'h0, m_data}, {24'h0, exp_word(1, b1)});
      chk("t4_stall_qid", {30'h0, m_qid}, 32'h1);
      @(negedge clk);
    end
    chk("t4_no_accept_in_stall", acc_q.size(), 0);
    m_ready = 1'b1;
    wait_log(8, 60, "t4");
    for (int i = 0; i < 8; i++) chk_entry("t4", i, 1, b1 + i);

    // 5: disable Q1 mid-burst, Q3 takes over, Q1 resumes after re-enable
    repeat (3) @(negedge clk);
    clear_log();
    b1 = wr_ptr[1];
    b3 = wr_ptr[3];
    rc = rinc_cnt[1];
    wr_ptr[1] += 8;
    @(negedge clk);
    chk("t5_rinc1_active", {28'h0, rinc}, 32'h2);
    @(negedge clk);
    wr_ptr[3] += 4;
    q_en = 4'b1101;
    #1;
    chk("t5_rinc1_cut", {28'h0, rinc}, 32'h0);
    wait_log(5, 40, "t5a");
    q_en = 4'hF;
    wait_log(12, 80, "t5b");
    chk_entry("t5_q1_first", 0, 1, b1);
    for (int i = 1; i < 5; i++) chk_entry("t5_q3", i, 3, b3 + i - 1);
    for (int i = 5; i < 12; i++) chk_entry("t5_q1_resume", i, 1, b1 + i - 4);
    chk("t5_rinc1_pulses", rinc_cnt[1] - rc, 8);

    // 6: reset while a word is in flight; Q0 must win first afterwards
    repeat (3) @(negedge clk);
    b0 = wr_ptr[0];
    b3 = wr_ptr[3];
    wr_ptr[0] += 4;
    wr_ptr[3] += 8;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_valid", {31'h0, m_valid}, 32'h1);
    chk("t6_pre_qid", {30'h0, m_qid}, 32'h3);
    rrst = 1'b1;
    #1;
    chk("t6_rinc_in_reset", {28'h0, rinc}, 32'h0);
    @(negedge clk);
    chk("t6_valid", {31'h0, m_valid}, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_data", {24'h0, m_data}, 32'h0);
    chk("t6_qid", {30'h0, m_qid}, 32'h0);
    rrst = 1'b0;
    clear_log();
    wait_log(11, 100, "t6");
    for (int i = 0; i < 4; i++) chk_entry("t6_q0", i, 0, b0 + i);
    for (int i = 4; i < 11; i++) chk_entry("t6_q3", i, 3, b3 + i - 3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
